// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
// Stage 1 registers bit and group propagate/generate terms; stage 2 resolves carries and the sum.
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_param_check
        $error("cla_adder_pipe: WIDTH must be a non-zero multiple of GROUP");
    end

    logic             v1_q, v2_q;
    logic [WIDTH-1:0] p_q, g_q, p_d, g_d, b_eff;
    logic [NG-1:0]    gp_q, gg_q, gp_d, gg_d;
    logic             c0_q, c0_d;
    logic [WIDTH-1:0] sum_q, sum_d, bc;
    logic [NG:0]      gc;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             s1_term, s2_term, s2_acc;
    logic             adv;

    assign adv       = !v2_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        b_eff   = sub ? ~b : b;
        c0_d    = sub | cin;
        p_d     = a ^ b_eff;
        g_d     = a & b_eff;
        gp_d    = '0;
        gg_d    = '0;
        s1_term = 1'b0;
        for (int j = 0; j < NG; j++) begin
            gp_d[j] = &p_d[j*GROUP +: GROUP];
            for (int k = 0; k < GROUP; k++) begin
                s1_term = g_d[j*GROUP+k];
                for (int m = k + 1; m < GROUP; m++)
                    s1_term = s1_term & p_d[j*GROUP+m];
                gg_d[j] = gg_d[j] | s1_term;
            end
        end
    end

    // Group and bit carries are built as sum-of-products so no carry ripples between terms.
    always_comb begin
        gc      = '0;
        bc      = '0;
        s2_term = 1'b0;
        s2_acc  = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            s2_acc = c0_q;
            for (int m = 0; m < j; m++)
                s2_acc = s2_acc & gp_q[m];
            for (int k = 0; k < j; k++) begin
                s2_term = gg_q[k];
                for (int m = k + 1; m < j; m++)
                    s2_term = s2_term & gp_q[m];
                s2_acc = s2_acc | s2_term;
            end
            gc[j] = s2_acc;
        end
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                s2_acc = gc[j];
                for (int m = 0; m < i; m++)
                    s2_acc = s2_acc & p_q[j*GROUP+m];
                for (int k = 0; k < i; k++) begin
                    s2_term = g_q[j*GROUP+k];
                    for (int m = k + 1; m < i; m++)
                        s2_term = s2_term & p_q[j*GROUP+m];
                    s2_acc = s2_acc | s2_term;
                end
                bc[j*GROUP+i] = s2_acc;
            end
        end
        sum_d  = p_q ^ bc;
        cout_d = gc[NG];
        ovf_d  = bc[WIDTH-1] ^ gc[NG];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            p_q    <= '0;
            g_q    <= '0;
            gp_q   <= '0;
            gg_q   <= '0;
            c0_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            v1_q   <= in_valid;
            p_q    <= p_d;
            g_q    <= g_d;
            gp_q   <= gp_d;
            gg_q   <= gg_d;
            c0_q   <= c0_d;
            v2_q   <= v1_q;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed vectors, backpressure and reset sequences on a 16/4 instance,
// then random traffic on 16/4 and 32/8 instances sharing handshake inputs, checked against an arithmetic model.
module tb_cla_adder_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, cin, sub, out_ready;
    logic [31:0] a32, b32;
    logic        in_ready16, out_valid16, cout16, ovf16;
    logic [15:0] sum16;
    logic        in_ready32, out_valid32, cout32, ovf32;
    logic [31:0] sum32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    cla_adder_pipe #(.WIDTH(32), .GROUP(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin), .sub(sub),
        .out_valid(out_valid32), .out_ready(out_ready),
        .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference: plain integer add on the masked operands; overflow from operand/result signs.
    function automatic logic [33:0] ref_add(input logic [31:0] av, input logic [31:0] bv,
                                            input logic ci, input logic sb, input int w);
        logic [63:0] mask, ae, be, full;
        logic        sa, sbb, sr, c, o;
        mask = (64'd1 << w) - 64'd1;
        ae   = {32'd0, av} & mask;
        be   = {32'd0, (sb ? ~bv : bv)} & mask;
        full = ae + be + (sb ? 64'd1 : {63'd0, ci});
        c    = full[w];
        sa   = ae[w-1];
        sbb  = be[w-1];
        sr   = full[w-1];
        o    = (sa == sbb) && (sr != sa);
        ref_add = {o, c, full[31:0] & mask[31:0]};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        in_valid  = 1'b1;
        a32       = {16'h0, v.a};
        b32       = {16'h0, v.b};
        cin       = v.cin;
        sub       = v.sub;
        out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d in_ready", idx), in_ready16, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check($sformatf("vec%0d early_valid", idx), out_valid16, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check($sformatf("vec%0d out_valid", idx), out_valid16, 1'b1);
        check($sformatf("vec%0d sum", idx), sum16, v.s);
        check($sformatf("vec%0d cout", idx), cout16, v.co);
        check($sformatf("vec%0d ovf", idx), ovf16, v.ov);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [33:0] q16[$];
        logic [33:0] q32[$];
        logic [33:0] e;
        logic [15:0] psum16;
        logic [31:0] psum32;
        logic        pstall16, pstall32, saw_low;
        int          k, got, cyc, n_acc;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", out_valid16, 1'b0);
        check("rst sum", sum16, 16'h0);
        check("rst cout", cout16, 1'b0);
        check("rst ovf", ovf16, 1'b0);
        check("rst in_ready", in_ready16, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Backpressure: 8 beats a=b=k, cin=1, consumer stalls cycles 3..6.
        k = 0; got = 0; cyc = 0; saw_low = 1'b0; pstall16 = 1'b0; psum16 = '0;
        while (got < 8 && cyc < 40) begin
            @(negedge clk);
            in_valid  = (k < 8);
            a32       = 32'(k);
            b32       = 32'(k);
            cin       = 1'b1;
            sub       = 1'b0;
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (!in_ready16) saw_low = 1'b1;
            if (pstall16) check("bp hold", {out_valid16, sum16}, {1'b1, psum16});
            if (out_valid16 && out_ready) begin
                check("bp sum", {cout16, ovf16, sum16}, {2'b00, 16'(2 * got + 1)});
                got++;
            end
            if (in_valid && in_ready16) k++;
            pstall16 = out_valid16 && !out_ready;
            psum16   = sum16;
            cyc++;
        end
        check("bp beats out", got, 8);
        check("bp beats in", k, 8);
        check("bp in_ready dropped", saw_low, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);

        // Reset with two beats in flight; a beat offered during reset must be dropped.
        @(negedge clk);
        in_valid = 1'b1; a32 = 32'd1; b32 = 32'd2; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a32 = 32'd3; b32 = 32'd4;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; a32 = 32'd5; b32 = 32'd6;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("mid rst out_valid", out_valid16, 1'b0);
        check("mid rst sum", sum16, 16'h0);
        check("mid rst cout", cout16, 1'b0);
        check("mid rst ovf", ovf16, 1'b0);
        check("mid rst in_ready", in_ready16, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("no accept in rst", out_valid16, 1'b0);
        run_vec(vecs[1], 100);

        // Random traffic on both widths.
        do_reset();
        n_acc = 0; cyc = 0; pstall16 = 1'b0; pstall32 = 1'b0;
        while (n_acc < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid  = ($urandom_range(0, 3) != 0);
            a32       = $urandom;
            b32       = $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (pstall16) check("rand16 hold", {out_valid16, sum16}, {1'b1, psum16});
            if (pstall32) check("rand32 hold", {out_valid32, sum32}, {1'b1, psum32});
            if (out_valid16 && out_ready) begin
                if (q16.size() == 0) fail_event("rand16 spurious beat");
                else begin
                    e = q16.pop_front();
                    check("rand16 result", {ovf16, cout16, 16'h0, sum16}, e);
                end
            end
            if (out_valid32 && out_ready) begin
                if (q32.size() == 0) fail_event("rand32 spurious beat");
                else begin
                    e = q32.pop_front();
                    check("rand32 result", {ovf32, cout32, sum32}, e);
                end
            end
            if (in_valid && in_ready16) begin
                q16.push_back(ref_add(a32, b32, cin, sub, 16));
                n_acc++;
            end
            if (in_valid && in_ready32) q32.push_back(ref_add(a32, b32, cin, sub, 32));
            pstall16 = out_valid16 && !out_ready;
            pstall32 = out_valid32 && !out_ready;
            psum16   = sum16;
            psum32   = sum32;
        end
        if (n_acc < 10000) fail_event("random stimulus timed out");

        cyc = 0;
        while ((q16.size() != 0 || q32.size() != 0) && cyc < 10) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid16 && q16.size() != 0) begin
                e = q16.pop_front();
                check("drain16 result", {ovf16, cout16, 16'h0, sum16}, e);
            end
            if (out_valid32 && q32.size() != 0) begin
                e = q32.pop_front();
                check("drain32 result", {ovf32, cout32, sum32}, e);
            end
            cyc++;
        end
        check("q16 empty", q16.size(), 0);
        check("q32 empty", q32.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
